fp8_result_collector: RTL and testbench

FP8_RESULT_COLLECTOR -- requirements
Module: fp8_result_collector

---
 rtl/fp8_pkg.sv | 16 +
 rtl/fp8_unpack.sv | 17 +
 rtl/fp8_result_collector.sv | 115 +++++++++++
 tb/tb_fp8_result_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared FP8 field layout, collector state encoding and default timeout.
package fp8_pkg;

  localparam int unsigned SIGN_BIT        = 7;
  localparam int unsigned EXP_W           = 3;
  localparam int unsigned MANT_W          = 4;
  localparam int unsigned EXP_LSB         = MANT_W;
  localparam int unsigned FP8_W           = 1 + EXP_W + MANT_W;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

endpackage

// File: rtl/fp8_unpack.sv
// Combinational FP8 field decode with zero detect (sign is ignored for zero).
module fp8_unpack
  import fp8_pkg::*;
(
  input  logic [FP8_W-1:0]  value,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant,
  output logic              zero
);

  assign sign = value[SIGN_BIT];
  assign exp  = value[EXP_LSB +: EXP_W];
  assign mant = value[MANT_W-1:0];
  assign zero = (exp == '0) && (mant == '0);

endmodule

// File: rtl/fp8_result_collector.sv
// Collects FP8 adder results after a start request, with timeout and
// spurious-valid detection plus a wrapping transaction counter.
module fp8_result_collector
  import fp8_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [FP8_W-1:0]  sum,
  input  logic              valid,
  input  logic              clear_err,
  output logic [FP8_W-1:0]  result,
  output logic              result_sign,
  output logic [EXP_W-1:0]  result_exp,
  output logic [MANT_W-1:0] result_mant,
  output logic              result_zero,
  output logic              done,
  output logic              busy,
  output logic              timeout_err,
  output logic              spurious_err,
  output logic [7:0]        txn_count
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [FP8_W-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [7:0]       txn_q, txn_d;
  logic             terr_q, terr_d;
  logic             serr_q, serr_d;
  logic             timeout_ev, spurious_ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      txn_q    <= '0;
      terr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      txn_q    <= txn_d;
      terr_q   <= terr_d;
      serr_q   <= serr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    done_d      = 1'b0;
    txn_d       = txn_q;
    timeout_ev  = 1'b0;
    spurious_ev = 1'b0;
    unique case (state_q)
      StIdle: begin
        spurious_ev = valid;
        if (start) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (valid) begin
          result_d = sum;
          done_d   = 1'b1;
          txn_d    = txn_q + 8'd1;
          cnt_d    = '0;
          // A coincident start keeps us waiting for the next result.
          if (!start) state_d = StIdle;
        end else if (start) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          timeout_ev = 1'b1;
          cnt_d      = '0;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // New error events win over a simultaneous clear.
    terr_d = timeout_ev  | (terr_q & ~clear_err);
    serr_d = spurious_ev | (serr_q & ~clear_err);
  end

  always_comb begin
    result       = result_q;
    done         = done_q;
    busy         = (state_q == StWait);
    timeout_err  = terr_q;
    spurious_err = serr_q;
    txn_count    = txn_q;
  end

  fp8_unpack u_unpack (
    .value (result_q),
    .sign  (result_sign),
    .exp   (result_exp),
    .mant  (result_mant),
    .zero  (result_zero)
  );

endmodule

// File: tb/tb_fp8_result_collector.sv
// Scoreboard bench: a cycle-level reference model queues expectations, a monitor checks them.
module tb_fp8_result_collector;
  import fp8_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, valid = 1'b0, clear_err = 1'b0;
  logic [7:0] sum = '0;
  logic [7:0] result, txn_count;
  logic       result_sign, result_zero, done, busy, timeout_err, spurious_err;
  logic [2:0] result_exp;
  logic [3:0] result_mant;

  always #5 clk = ~clk;

  fp8_result_collector #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sum          (sum),
    .valid        (valid),
    .clear_err    (clear_err),
    .result       (result),
    .result_sign  (result_sign),
    .result_exp   (result_exp),
    .result_mant  (result_mant),
    .result_zero  (result_zero),
    .done         (done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .spurious_err (spurious_err),
    .txn_count    (txn_count)
  );

  // Shared decoder, checked here against plain arithmetic on expected values.
  logic [7:0] chk_val = '0;
  logic       u_sign, u_zero;
  logic [2:0] u_exp;
  logic [3:0] u_mant;
  fp8_unpack u_ref (
    .value (chk_val),
    .sign  (u_sign),
    .exp   (u_exp),
    .mant  (u_mant),
    .zero  (u_zero)
  );

  typedef struct {
    bit         done, busy, terr, serr;
    logic [7:0] res;
    int         txn;
  } snap_t;

  snap_t       snap_q[$];
  logic [15:0] cap_q[$];
  int          tests_run = 0;
  int          fails = 0;

  // Reference model state: waiting flag, busy cycles used, last capture, counters.
  bit         m_wait = 0, m_done = 0, m_terr = 0, m_serr = 0;
  int         m_used = 0, m_txn = 0;
  logic [7:0] m_res = '0;

  function automatic void check(string name, int act, int exp);
    tests_run++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model(bit s, bit v, logic [7:0] d, bit c, bit r);
    bit    tev = 0, sev = 0;
    snap_t n;
    m_done = 0;
    if (r) begin
      m_wait = 0; m_used = 0; m_res = '0; m_txn = 0; m_terr = 0; m_serr = 0;
    end else begin
      if (!m_wait) begin
        sev = v;
        if (s) begin m_wait = 1; m_used = 0; end
      end else if (v) begin
        m_res  = d;
        m_done = 1;
        m_txn  = (m_txn + 1) % 256;
        cap_q.push_back({d, 8'(m_txn)});
        if (s) m_used = 0;
        else m_wait = 0;
      end else if (s) begin
        m_used = 0;
      end else if (m_used + 1 == TO) begin
        tev = 1; m_wait = 0;
      end else begin
        m_used++;
      end
      m_terr = tev || (m_terr && !c);
      m_serr = sev || (m_serr && !c);
    end
    n.done = m_done; n.busy = m_wait; n.terr = m_terr; n.serr = m_serr;
    n.res  = m_res;  n.txn  = m_txn;
    snap_q.push_back(n);
  endfunction

  task automatic step(input bit s, input bit v, input logic [7:0] d, input bit c, input bit r);
    @(negedge clk);
    start = s; valid = v; sum = d; clear_err = c; reset = r;
    model(s, v, d, c, r);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  // Monitor: one expected snapshot per driven edge, plus capture scoreboard on done.
  always @(posedge clk) begin
    snap_t       s;
    logic [15:0] cp;
    #1;
    if (snap_q.size() != 0) begin
      s = snap_q.pop_front();
      chk_val = s.res;
      #1;
      check("done", done, s.done);
      check("busy", busy, s.busy);
      check("timeout_err", timeout_err, s.terr);
      check("spurious_err", spurious_err, s.serr);
      check("result", result, s.res);
      check("txn_count", txn_count, s.txn);
      check("result_sign", result_sign, s.res / 128);
      check("result_exp", result_exp, (s.res / 16) % 8);
      check("result_mant", result_mant, s.res % 16);
      check("result_zero", result_zero, int'((s.res % 128) == 0));
      check("unpack_exp", u_exp, (s.res / 16) % 8);
      check("unpack_zero", u_zero, int'((s.res % 128) == 0));
      if (done) begin
        if (cap_q.size() == 0) begin
          check("done_without_capture", 1, 0);
        end else begin
          cp = cap_q.pop_front();
          check("capture_value", result, cp[15:8]);
          check("capture_txn", txn_count, cp[7:0]);
        end
      end
    end
  end

  initial begin
    int bc;
    int t0;
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    after_edge();
    check("reset_busy", busy, 0);
    check("reset_zero", result_zero, 1);
    check("reset_result", result, 8'h00);

    // Basic capture three cycles after start
    step(1, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'hB1, 0, 0);
    after_edge();
    check("basic_result", result, 8'hB1);
    check("basic_sign", result_sign, 1);
    check("basic_exp", result_exp, 3);
    check("basic_mant", result_mant, 1);
    check("basic_done", done, 1);
    check("basic_txn", txn_count, 1);
    check("basic_busy", busy, 0);
    step(0, 0, 8'h00, 0, 0);
    after_edge();
    check("basic_done_pulse", done, 0);

    // Timeout: busy for exactly TO cycles, result kept, later valid is spurious
    step(1, 0, 8'h00, 0, 0);
    after_edge();
    bc = int'(busy);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8'h00, 0, 0);
      after_edge();
      bc += int'(busy);
    end
    check("timeout_busy_cycles", bc, TO);
    check("timeout_flag", timeout_err, 1);
    check("timeout_result", result, 8'hB1);
    step(0, 1, 8'h55, 0, 0);
    after_edge();
    check("late_valid_spurious", spurious_err, 1);
    check("late_valid_result", result, 8'hB1);

    // Spurious and clear interaction
    step(0, 0, 8'h00, 1, 0);
    after_edge();
    check("clear_terr", timeout_err, 0);
    check("clear_serr", spurious_err, 0);
    step(0, 1, 8'h12, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'h34, 1, 0);
    after_edge();
    check("clear_vs_event", spurious_err, 1);
    check("spurious_result", result, 8'hB1);
    step(0, 0, 8'h00, 1, 0);

    // Back-to-back capture
    t0 = m_txn;
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'h80, 0, 0);
    after_edge();
    check("b2b_result", result, 8'h80);
    check("b2b_zero", result_zero, 1);
    check("b2b_busy", busy, 1);
    step(0, 1, 8'h25, 0, 0);
    after_edge();
    check("b2b_result2", result, 8'h25);
    check("b2b_txn", txn_count, (t0 + 2) % 256);

    // Reset wins over a coincident valid
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h77, 0, 1);
    after_edge();
    check("rst_done", done, 0);
    check("rst_result", result, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_txn", txn_count, 0);

    // Counter wrap after 256 completions
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 8'h00, 0, 0);
      step(0, 1, 8'($urandom_range(0, 255)), 0, 0);
    end
    after_edge();
    check("wrap_txn", txn_count, 0);
    check("wrap_terr", timeout_err, 0);
    check("wrap_serr", spurious_err, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 100) < 15, ($urandom % 100) < 20, 8'($urandom), ($urandom % 100) < 5,
           ($urandom % 1000) < 8);
    end

    step(0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #5;
    check("snapshots_drained", snap_q.size(), 0);
    check("captures_drained", cap_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
